// File: rtl/div16_seq.sv
// rtl/div16_seq.sv - sequential fp16 restoring divider, one quotient bit per clock
// Truncating quotient; zero operands are the only special class, no NaN/Inf/denormals.
module div16_seq #(
    parameter int tam = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [tam-1:0] a,
    input  logic [tam-1:0] b,
    output logic [tam-1:0] result,
    output logic           done,
    output logic           busy,
    output logic           dbz,
    output logic           ovf
);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [11:0] r_rem;
    logic [10:0] r_div;
    logic [11:0] r_q;
    logic        r_sign;
    logic [4:0]  r_ea;
    logic [4:0]  r_eb;
    logic        r_az;
    logic        r_bz;
    logic [15:0] r_result;
    logic        r_done;
    logic        r_busy;
    logic        r_dbz;
    logic        r_ovf;

    logic        w_load;
    logic        w_step;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_qbit;
    logic [11:0] w_sub;
    logic signed [6:0] w_e_hi;
    logic signed [6:0] w_e;
    logic [9:0]  w_mant;
    logic [15:0] w_res;
    logic        w_dbz;
    logic        w_ovf;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DIV;
            S_DIV:   if (r_cnt == 4'd11) w_next = S_NORM;
            S_NORM:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load     = (r_state == S_IDLE) && start;
        w_step     = (r_state == S_DIV);
        w_busy_nxt = (w_next != S_IDLE);
        w_done_nxt = (r_state == S_NORM);
    end

    // r stays below 2*d, so the shifted partial remainder always fits in 12 bits
    always_comb begin
        w_qbit = (r_rem >= {1'b0, r_div});
        w_sub  = w_qbit ? (r_rem - {1'b0, r_div}) : r_rem;
    end

    always_comb begin
        w_e_hi = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb}) + 7'sd15;
        w_e    = r_q[11] ? w_e_hi : (w_e_hi - 7'sd1);
        w_mant = r_q[11] ? r_q[10:1] : r_q[9:0];
        w_res  = {r_sign, w_e[4:0], w_mant};
        w_dbz  = 1'b0;
        w_ovf  = 1'b0;
        if (r_bz) begin
            w_res = {r_sign, 5'h1F, 10'h000};
            w_dbz = 1'b1;
        end else if (r_az) begin
            w_res = 16'h0000;
        end else if (w_e <= 7'sd0) begin
            w_res = 16'h0000;
        end else if (w_e >= 7'sd31) begin
            w_res = {r_sign, 5'h1F, 10'h000};
            w_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 4'd0;
            r_rem    <= 12'd0;
            r_div    <= 11'd0;
            r_q      <= 12'd0;
            r_sign   <= 1'b0;
            r_ea     <= 5'd0;
            r_eb     <= 5'd0;
            r_az     <= 1'b0;
            r_bz     <= 1'b0;
            r_result <= 16'h0000;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            r_busy <= w_busy_nxt;
            if (w_load) begin
                r_cnt  <= 4'd0;
                r_rem  <= {2'b01, a[9:0]};
                r_div  <= {1'b1, b[9:0]};
                r_q    <= 12'd0;
                r_sign <= a[15] ^ b[15];
                r_ea   <= a[14:10];
                r_eb   <= b[14:10];
                r_az   <= (a[14:0] == 15'd0);
                r_bz   <= (b[14:0] == 15'd0);
            end else if (w_step) begin
                r_rem <= w_sub << 1;
                r_q   <= {r_q[10:0], w_qbit};
                r_cnt <= (r_cnt == 4'd11) ? 4'd0 : (r_cnt + 4'd1);
            end
            if (r_state == S_NORM) begin
                r_result <= w_res;
                r_dbz    <= w_dbz;
                r_ovf    <= w_ovf;
            end
        end
    end

    assign result = r_result;
    assign done   = r_done;
    assign busy   = r_busy;
    assign dbz    = r_dbz;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_div16_seq.sv
// tb/tb_div16_seq.sv - self-checking bench for div16_seq against an arithmetic model
module tb_div16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] result;
    logic        done;
    logic        busy;
    logic        dbz;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    div16_seq #(.tam(16)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .result(result), .done(done), .busy(busy), .dbz(dbz), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // returns {dbz, ovf, result}
    function automatic logic [17:0] ref_div(input logic [15:0] x, input logic [15:0] y);
        int mx, my, q, e, ea, eb;
        logic s;
        logic [9:0] mant;
        s  = x[15] ^ y[15];
        mx = 1024 + int'(x[9:0]);
        my = 1024 + int'(y[9:0]);
        ea = int'(x[14:10]);
        eb = int'(y[14:10]);
        q  = (mx * 2048) / my;
        if (q >= 2048) begin
            mant = 10'((q / 2) % 1024);
            e    = ea - eb + 15;
        end else begin
            mant = 10'(q % 1024);
            e    = ea - eb + 14;
        end
        if (y[14:0] == 15'd0) return {2'b10, s, 5'h1F, 10'h000};
        if (x[14:0] == 15'd0) return 18'h0;
        if (e <= 0)           return 18'h0;
        if (e >= 31)          return {2'b01, s, 5'h1F, 10'h000};
        return {2'b00, s, 5'(e), mant};
    endfunction

    task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    logic        m_pend = 1'b0;
    int          m_left = 0;
    logic [17:0] m_exp  = 18'h0;
    logic        m_done = 1'b0;
    logic [15:0] m_res  = 16'h0;
    logic        m_dbz  = 1'b0;
    logic        m_ovf  = 1'b0;

    // timing model: an accepted op occupies 13 edges, done appears after the 13th
    always @(posedge clk) begin
        cyc++;
        m_done = 1'b0;
        if (rst) begin
            m_pend = 1'b0;
            m_left = 0;
            m_res  = 16'h0;
            m_dbz  = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_pend) begin
            m_left--;
            if (m_left == 0) begin
                m_pend = 1'b0;
                m_done = 1'b1;
                {m_dbz, m_ovf, m_res} = m_exp;
            end
        end else if (start) begin
            m_pend = 1'b1;
            m_left = 13;
            m_exp  = ref_div(a, b);
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("done",   18'(done),   18'(m_done));
            chk("busy",   18'(busy),   18'(m_pend));
            chk("result", 18'(result), 18'(m_res));
            chk("dbz",    18'(dbz),    18'(m_dbz));
            chk("ovf",    18'(ovf),    18'(m_ovf));
        end
    end

    task automatic start_op(input logic [15:0] x, input logic [15:0] y);
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int k, output int nb);
        k  = 0;
        nb = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                k = i;
                break;
            end
            if (busy) nb++;
        end
        chk("done_seen", 18'(k != 0), 18'h1);
    endtask

    task automatic check_out(input logic [15:0] er, input logic ed, input logic eo);
        chk("lit_result", 18'(result), 18'(er));
        chk("lit_dbz",    18'(dbz),    18'(ed));
        chk("lit_ovf",    18'(ovf),    18'(eo));
    endtask

    task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] er, input logic ed, input logic eo);
        int k, nb;
        start_op(x, y);
        wait_done(k, nb);
        chk("latency",     18'(k),  18'd14);
        chk("busy_cycles", 18'(nb), 18'd13);
        check_out(er, ed, eo);
    endtask

    initial begin
        int k, nb, nd;
        rst   = 1'b1;
        start = 1'b0;
        a     = 16'h0;
        b     = 16'h0;

        chk("model_1_3",  ref_div(16'h3C00, 16'h4200), 18'h03555);
        chk("model_ovf",  ref_div(16'h7800, 16'h0C00), 18'h17C00);
        chk("model_dbz",  ref_div(16'h3C00, 16'h0000), 18'h27C00);
        chk("model_unf",  ref_div(16'h0400, 16'h7800), 18'h00000);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_out(16'h0000, 1'b0, 1'b0);
        chk("rst_busy", 18'(busy), 18'h0);

        run_op(16'h4200, 16'h3E00, 16'h4000, 1'b0, 1'b0);
        run_op(16'h3C00, 16'h4200, 16'h3555, 1'b0, 1'b0);
        run_op(16'hC600, 16'h4000, 16'hC200, 1'b0, 1'b0);
        run_op(16'h3C00, 16'h0000, 16'h7C00, 1'b1, 1'b0);
        run_op(16'h8000, 16'h4000, 16'h0000, 1'b0, 1'b0);
        run_op(16'h7800, 16'h0C00, 16'h7C00, 1'b0, 1'b1);
        run_op(16'h0400, 16'h7800, 16'h0000, 1'b0, 1'b0);

        // busy start is ignored and operand changes mid-operation have no effect
        start_op(16'h4200, 16'h3E00);
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        a = 16'h3C00;
        b = 16'h0000;
        @(posedge clk);
        #1 start = 1'b0;
        a = 16'hFFFF;
        b = 16'h1234;
        wait_done(k, nb);
        check_out(16'h4000, 1'b0, 1'b0);

        // abort mid-division; simultaneous start loses to reset
        repeat (3) @(posedge clk);
        #1;
        start_op(16'h7800, 16'h0C00);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        start = 1'b1;
        a = 16'h3C00;
        b = 16'h4200;
        @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_out(16'h0000, 1'b0, 1'b0);
        chk("abort_busy", 18'(busy), 18'h0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("no_done_after_rst", 18'(nd), 18'h0);

        run_op(16'h3C00, 16'h4200, 16'h3555, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
